// File: rtl/jo_regfile_pkg.sv
// Shared widths, the zero-register code and the register code/data types
// for the write-back register bank.
package jo_regfile_pkg;
  localparam int DATA_W = 32;
  localparam int CODE_W = 8;
  localparam logic [CODE_W-1:0] ZERO_CODE = '0;

  typedef logic [CODE_W-1:0] reg_code_t;
  typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/reg_writeback_bank_if.sv
// Write-back, reservation and operand-read bus between the issue logic /
// execution units (master) and the register bank (slave).
interface reg_writeback_bank_if;
  import jo_regfile_pkg::*;

  logic                REG_write_back_flag;
  reg_code_t           REG_write_back_code;
  reg_data_t           REG_write_back_data;
  logic                RSV_valid;
  reg_code_t           RSV_code;
  logic                RSV_ready;
  reg_code_t           RD_A_code;
  reg_data_t           RD_A_data;
  logic                RD_A_busy;
  reg_code_t           RD_B_code;
  reg_data_t           RD_B_data;
  logic                RD_B_busy;
  logic                WB_ack;
  logic                WB_err;
  logic                ERR_clr;
  logic [CODE_W:0]     PENDING_cnt;

  modport master (
    output REG_write_back_flag, REG_write_back_code, REG_write_back_data,
    output RSV_valid, RSV_code, RD_A_code, RD_B_code, ERR_clr,
    input  RSV_ready, RD_A_data, RD_A_busy, RD_B_data, RD_B_busy,
    input  WB_ack, WB_err, PENDING_cnt
  );

  modport slave (
    input  REG_write_back_flag, REG_write_back_code, REG_write_back_data,
    input  RSV_valid, RSV_code, RD_A_code, RD_B_code, ERR_clr,
    output RSV_ready, RD_A_data, RD_A_busy, RD_B_data, RD_B_busy,
    output WB_ack, WB_err, PENDING_cnt
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Busy scoreboard: one reservation bit per register, reservation readiness,
// outstanding-reservation count and the sticky unreserved-write-back error.
module reg_scoreboard #(
  parameter int                 CODE_W    = jo_regfile_pkg::CODE_W,
  parameter logic [CODE_W-1:0]  ZERO_CODE = jo_regfile_pkg::ZERO_CODE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_flag,
  input  logic [CODE_W-1:0] wb_code,
  input  logic              rsv_valid,
  input  logic [CODE_W-1:0] rsv_code,
  output logic              rsv_ready,
  input  logic [CODE_W-1:0] rd_a_code,
  output logic              rd_a_busy,
  input  logic [CODE_W-1:0] rd_b_code,
  output logic              rd_b_busy,
  input  logic              err_clr,
  output logic              wb_err,
  output logic [CODE_W:0]   pending_cnt
);
  localparam int NUM_REGS = 2**CODE_W;
  localparam logic [CODE_W:0] CNT_MAX = (CODE_W+1)'(NUM_REGS - 1);

  logic [NUM_REGS-1:0] busy_p1;
  logic                wb_p0;
  logic                rsv_acc_p0;
  logic                dec_p0;

  function automatic logic [CODE_W:0] cnt_next(input logic [CODE_W:0] c,
                                               input logic inc, input logic dec);
    if (inc && !dec && c != CNT_MAX) return c + 1'b1;
    if (dec && !inc && c != '0)      return c - 1'b1;
    return c;
  endfunction

  function automatic logic port_busy(input logic [CODE_W-1:0] code,
                                     input logic [NUM_REGS-1:0] busy_vec,
                                     input logic wb, input logic [CODE_W-1:0] wcode);
    if (code == ZERO_CODE)       return 1'b0;
    if (wb && wcode == code)     return 1'b0;
    return busy_vec[code];
  endfunction

  always_comb begin
    wb_p0      = wb_flag && (wb_code != ZERO_CODE);
    rsv_ready  = (rsv_code == ZERO_CODE) || !busy_p1[rsv_code] ||
                 (wb_p0 && wb_code == rsv_code);
    rsv_acc_p0 = rsv_valid && rsv_ready && (rsv_code != ZERO_CODE);
    dec_p0     = wb_p0 && busy_p1[wb_code];
    rd_a_busy  = port_busy(rd_a_code, busy_p1, wb_p0, wb_code);
    rd_b_busy  = port_busy(rd_b_code, busy_p1, wb_p0, wb_code);
  end

  // p0 -> p1: scoreboard update; a same-cycle reservation overrides the clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_p1     <= '0;
      pending_cnt <= '0;
      wb_err      <= 1'b0;
    end else begin
      if (wb_p0)      busy_p1[wb_code]  <= 1'b0;
      if (rsv_acc_p0) busy_p1[rsv_code] <= 1'b1;
      pending_cnt <= cnt_next(pending_cnt, rsv_acc_p0, dec_p0);
      if (wb_p0 && !busy_p1[wb_code]) wb_err <= 1'b1;
      else if (err_clr)               wb_err <= 1'b0;
    end
  end
endmodule

// File: rtl/reg_writeback_bank.sv
// Register bank at the receiving end of the write-back bus: data array,
// operand read ports with write-back bypass, and the registered commit ack.
module reg_writeback_bank #(
  parameter int                 DATA_W    = jo_regfile_pkg::DATA_W,
  parameter int                 CODE_W    = jo_regfile_pkg::CODE_W,
  parameter logic [CODE_W-1:0]  ZERO_CODE = jo_regfile_pkg::ZERO_CODE
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  reg_writeback_bank_if.slave  bus
);
  localparam int NUM_REGS = 2**CODE_W;

  logic [DATA_W-1:0] regs_p1 [NUM_REGS];
  logic              wb_p0;
  logic              ack_p1;
  logic              rsv_ready_p0;
  logic              rd_a_busy_p0;
  logic              rd_b_busy_p0;
  logic              wb_err_p1;
  logic [CODE_W:0]   pending_p1;

  function automatic logic [DATA_W-1:0] port_data(input logic [CODE_W-1:0] code,
                                                  input logic [DATA_W-1:0] stored,
                                                  input logic wb,
                                                  input logic [CODE_W-1:0] wcode,
                                                  input logic [DATA_W-1:0] wdata);
    if (code == ZERO_CODE)   return '0;
    if (wb && wcode == code) return wdata;
    return stored;
  endfunction

  assign wb_p0 = bus.REG_write_back_flag && (bus.REG_write_back_code != ZERO_CODE);

  // p0 -> p1: commit and ack; the zero register is never written
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_REGS; i++) regs_p1[i] <= '0;
      ack_p1 <= 1'b0;
    end else begin
      if (wb_p0) regs_p1[bus.REG_write_back_code] <= bus.REG_write_back_data;
      ack_p1 <= wb_p0;
    end
  end

  reg_scoreboard #(
    .CODE_W    (CODE_W),
    .ZERO_CODE (ZERO_CODE)
  ) u_scoreboard (
    .clk         (CLK),
    .rst_n       (RST_N),
    .wb_flag     (bus.REG_write_back_flag),
    .wb_code     (bus.REG_write_back_code),
    .rsv_valid   (bus.RSV_valid),
    .rsv_code    (bus.RSV_code),
    .rsv_ready   (rsv_ready_p0),
    .rd_a_code   (bus.RD_A_code),
    .rd_a_busy   (rd_a_busy_p0),
    .rd_b_code   (bus.RD_B_code),
    .rd_b_busy   (rd_b_busy_p0),
    .err_clr     (bus.ERR_clr),
    .wb_err      (wb_err_p1),
    .pending_cnt (pending_p1)
  );

  always_comb begin
    bus.RD_A_data   = port_data(bus.RD_A_code, regs_p1[bus.RD_A_code], wb_p0,
                                bus.REG_write_back_code, bus.REG_write_back_data);
    bus.RD_B_data   = port_data(bus.RD_B_code, regs_p1[bus.RD_B_code], wb_p0,
                                bus.REG_write_back_code, bus.REG_write_back_data);
    bus.RD_A_busy   = rd_a_busy_p0;
    bus.RD_B_busy   = rd_b_busy_p0;
    bus.RSV_ready   = rsv_ready_p0;
    bus.WB_ack      = ack_p1;
    bus.WB_err      = wb_err_p1;
    bus.PENDING_cnt = pending_p1;
  end
endmodule

// File: tb/tb_reg_writeback_bank.sv
// Bench for reg_writeback_bank: directed vector table followed by random
// traffic compared against an array-based reference model.
module tb_reg_writeback_bank;
  import jo_regfile_pkg::*;

  logic CLK;
  logic RST_N;
  reg_writeback_bank_if bus ();

  reg_writeback_bank dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst_n;
    logic        wb_flag;
    logic [7:0]  wb_code;
    logic [31:0] wb_data;
    logic        rsv_valid;
    logic [7:0]  rsv_code;
    logic [7:0]  rd_a;
    logic        clr;
    logic        e_rdy;
    logic [31:0] e_a_data;
    logic        e_a_busy;
    logic        e_ack;
    logic        e_err;
    logic [8:0]  e_cnt;
  } vec_t;

  vec_t vecs [18];

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_reg  [256];
  bit          m_busy [256];
  bit          m_ack;
  bit          m_err;

  function automatic vec_t mk(logic rst_n, logic wbf, logic [7:0] wbc, logic [31:0] wbd,
                              logic rv, logic [7:0] rc, logic [7:0] ra, logic clr,
                              logic rdy, logic [31:0] ad, logic ab,
                              logic ack, logic err, logic [8:0] cnt);
    vec_t v;
    v.rst_n = rst_n; v.wb_flag = wbf; v.wb_code = wbc; v.wb_data = wbd;
    v.rsv_valid = rv; v.rsv_code = rc; v.rd_a = ra; v.clr = clr;
    v.e_rdy = rdy; v.e_a_data = ad; v.e_a_busy = ab;
    v.e_ack = ack; v.e_err = err; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst_n, input logic wbf, input logic [7:0] wbc,
                       input logic [31:0] wbd, input logic rv, input logic [7:0] rc,
                       input logic [7:0] ra, input logic [7:0] rb, input logic clr);
    RST_N = rst_n;
    bus.REG_write_back_flag = wbf;
    bus.REG_write_back_code = wbc;
    bus.REG_write_back_data = wbd;
    bus.RSV_valid = rv;
    bus.RSV_code  = rc;
    bus.RD_A_code = ra;
    bus.RD_B_code = rb;
    bus.ERR_clr   = clr;
  endtask

  function automatic bit m_wb();
    return bus.REG_write_back_flag && bus.REG_write_back_code != 8'd0;
  endfunction

  function automatic bit m_rdy();
    return bus.RSV_code == 8'd0 || !m_busy[bus.RSV_code] ||
           (m_wb() && bus.REG_write_back_code == bus.RSV_code);
  endfunction

  function automatic logic [31:0] m_rd_data(input logic [7:0] code);
    if (code == 8'd0) return 32'd0;
    if (m_wb() && bus.REG_write_back_code == code) return bus.REG_write_back_data;
    return m_reg[code];
  endfunction

  function automatic bit m_rd_busy(input logic [7:0] code);
    if (code == 8'd0) return 1'b0;
    if (m_wb() && bus.REG_write_back_code == code) return 1'b0;
    return m_busy[code];
  endfunction

  function automatic int m_pending();
    int n = 0;
    for (int i = 0; i < 256; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  // Applies one rising edge to the model using the currently driven inputs.
  task automatic model_edge();
    bit wb, rdy;
    if (!RST_N) begin
      for (int i = 0; i < 256; i++) begin
        m_reg[i]  = 32'd0;
        m_busy[i] = 1'b0;
      end
      m_ack = 1'b0;
      m_err = 1'b0;
    end else begin
      wb  = m_wb();
      rdy = m_rdy();
      m_ack = wb;
      if (wb && !m_busy[bus.REG_write_back_code]) m_err = 1'b1;
      else if (bus.ERR_clr) m_err = 1'b0;
      if (wb) begin
        m_reg[bus.REG_write_back_code]  = bus.REG_write_back_data;
        m_busy[bus.REG_write_back_code] = 1'b0;
      end
      if (bus.RSV_valid && rdy && bus.RSV_code != 8'd0) m_busy[bus.RSV_code] = 1'b1;
    end
  endtask

  task automatic clock_edge();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  initial begin
    vecs[0]  = mk(1,0,8'h00,32'h0,        0,8'h05,8'h05,0, 1,32'h0,        0, 0,0,9'd0);
    vecs[1]  = mk(1,0,8'h00,32'h0,        1,8'h05,8'h05,0, 1,32'h0,        0, 0,0,9'd1);
    vecs[2]  = mk(1,0,8'h00,32'h0,        0,8'h05,8'h05,0, 0,32'h0,        1, 0,0,9'd1);
    vecs[3]  = mk(1,1,8'h05,32'hDEADBEEF, 0,8'h05,8'h05,0, 1,32'hDEADBEEF, 0, 1,0,9'd0);
    vecs[4]  = mk(1,1,8'h00,32'h12345678, 0,8'h00,8'h00,0, 1,32'h0,        0, 0,0,9'd0);
    vecs[5]  = mk(1,0,8'h00,32'h0,        0,8'h05,8'h05,0, 1,32'hDEADBEEF, 0, 0,0,9'd0);
    vecs[6]  = mk(1,1,8'h10,32'h11,       0,8'h00,8'h10,0, 1,32'h11,       0, 1,1,9'd0);
    vecs[7]  = mk(1,0,8'h00,32'h0,        0,8'h00,8'h10,0, 1,32'h11,       0, 0,1,9'd0);
    vecs[8]  = mk(1,0,8'h00,32'h0,        0,8'h00,8'h10,1, 1,32'h11,       0, 0,0,9'd0);
    vecs[9]  = mk(1,1,8'h20,32'h22,       0,8'h00,8'h20,1, 1,32'h22,       0, 1,1,9'd0);
    vecs[10] = mk(1,0,8'h00,32'h0,        0,8'h00,8'h20,1, 1,32'h22,       0, 0,0,9'd0);
    vecs[11] = mk(1,0,8'h00,32'h0,        1,8'h07,8'h07,0, 1,32'h0,        0, 0,0,9'd1);
    vecs[12] = mk(1,1,8'h07,32'hA5,       1,8'h07,8'h07,0, 1,32'hA5,       0, 1,0,9'd1);
    vecs[13] = mk(1,0,8'h00,32'h0,        0,8'h07,8'h07,0, 0,32'hA5,       1, 0,0,9'd1);
    vecs[14] = mk(1,1,8'h07,32'h1,        0,8'h07,8'h07,0, 1,32'h1,        0, 1,0,9'd0);
    vecs[15] = mk(1,0,8'h00,32'h0,        1,8'h03,8'h03,0, 1,32'h0,        0, 0,0,9'd1);
    vecs[16] = mk(0,1,8'h03,32'h33,       0,8'h00,8'h00,0, 1,32'h0,        0, 0,0,9'd0);
    vecs[17] = mk(1,0,8'h00,32'h0,        0,8'h03,8'h03,0, 1,32'h0,        0, 0,0,9'd0);

    drive(0, 0, 8'h00, 32'h0, 0, 8'h00, 8'h00, 8'h00, 0);
    clock_edge();
    clock_edge();

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].rst_n, vecs[i].wb_flag, vecs[i].wb_code, vecs[i].wb_data,
            vecs[i].rsv_valid, vecs[i].rsv_code, vecs[i].rd_a, 8'h00, vecs[i].clr);
      #1;
      chk($sformatf("v%0d RSV_ready", i), 32'(bus.RSV_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d RD_A_data", i), bus.RD_A_data, vecs[i].e_a_data);
      chk($sformatf("v%0d RD_A_busy", i), 32'(bus.RD_A_busy), 32'(vecs[i].e_a_busy));
      clock_edge();
      chk($sformatf("v%0d WB_ack", i), 32'(bus.WB_ack), 32'(vecs[i].e_ack));
      chk($sformatf("v%0d WB_err", i), 32'(bus.WB_err), 32'(vecs[i].e_err));
      chk($sformatf("v%0d PENDING_cnt", i), 32'(bus.PENDING_cnt), 32'(vecs[i].e_cnt));
    end

    for (int n = 0; n < 1500; n++) begin
      drive($urandom_range(0, 63) != 0, $urandom_range(0, 1) == 1,
            8'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 1) == 1, 8'($urandom_range(0, 7)),
            8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
            $urandom_range(0, 7) == 0);
      #1;
      chk("rnd RSV_ready", 32'(bus.RSV_ready), 32'(m_rdy()));
      chk("rnd RD_A_data", bus.RD_A_data, m_rd_data(bus.RD_A_code));
      chk("rnd RD_A_busy", 32'(bus.RD_A_busy), 32'(m_rd_busy(bus.RD_A_code)));
      chk("rnd RD_B_data", bus.RD_B_data, m_rd_data(bus.RD_B_code));
      chk("rnd RD_B_busy", 32'(bus.RD_B_busy), 32'(m_rd_busy(bus.RD_B_code)));
      clock_edge();
      chk("rnd WB_ack", 32'(bus.WB_ack), 32'(m_ack));
      chk("rnd WB_err", 32'(bus.WB_err), 32'(m_err));
      chk("rnd PENDING_cnt", 32'(bus.PENDING_cnt), 32'(m_pending()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_writeback_bank.md
Name: reg_writeback_bank

Overview:
- Receiving end of the register write-back bus: the target of REG_write_back_flag, REG_write_back_code and REG_write_back_data.
- Holds the architectural register array and a busy scoreboard.
  - Issue reserves a destination register before an execution unit (ALU, STACK, JMP, DMA, SCHED, UART) runs.
  - The write-back commits data and clears the reservation.
- Exposes two operand read ports with same-cycle write-back bypass and busy indication, used by issue for hazard stalls.

Parameters:
- DATA_W, 32, register and write-back data width
- CODE_W, 8, register code width; NUM_REGS = 2**CODE_W
- ZERO_CODE, 0, hard-wired zero register code

Ports:
- CLK  in  1  single system clock, rising edge
- RST_N  in  1  synchronous, active-low reset, sampled on rising CLK
- REG_write_back_flag  in  1  write-back valid this cycle
- REG_write_back_code  in  CODE_W  destination register
- REG_write_back_data  in  DATA_W  value to commit
- RSV_valid  in  1  issue requests reservation of RSV_code
- RSV_code  in  CODE_W  register to reserve
- RSV_ready  out  1  reservation can be accepted this cycle (combinational)
- RD_A_code  in  CODE_W  read port A address
- RD_A_data  out  DATA_W  read port A data (combinational)
- RD_A_busy  out  1  port A register still pending
- RD_B_code / RD_B_data / RD_B_busy: same as port A
- WB_ack  out  1  registered pulse, write-back committed
- WB_err  out  1  sticky: write-back hit an unreserved register
- ERR_clr  in  1  clears WB_err
- PENDING_cnt  out  CODE_W+1  number of busy registers

Behaviour:
- Reset (RST_N=0 at rising CLK):
  - All registers are 0 and all busy bits are 0.
  - WB_ack=0, WB_err=0, PENDING_cnt=0.
  - A write-back or reservation presented in the reset cycle is dropped.
- Write-back accept: wb = REG_write_back_flag && code != ZERO_CODE.
  - On the rising edge: reg[code] <= data and busy[code] <= 0.
  - Write-back to ZERO_CODE is discarded with no ack and no error.
- WB_ack: 1 in the cycle after each accepted wb, otherwise 0. Latency is 1 cycle and there is no backpressure; the bank always accepts.
- WB_err:
  - Set on the edge after an accepted wb whose busy[code] was 0.
  - Cleared by ERR_clr. If set and clear occur in the same cycle, set wins.
- Reservation:
  - RSV_ready = (RSV_code == ZERO_CODE) || !busy[RSV_code] || (wb && REG_write_back_code == RSV_code).
  - Accepted when RSV_valid && RSV_ready; then busy[RSV_code] <= 1. ZERO_CODE never becomes busy.
  - Same-cycle wb and reserve on the same code: data commits and busy ends at 1 (the new reservation wins).
- Read ports (combinational, per port):
  - Code == ZERO_CODE: data 0, busy 0.
  - Else if wb && code matches: data = REG_write_back_data, busy 0 (bypass).
  - Else: data = reg[code], busy = busy[code].
- PENDING_cnt (registered):
  - +1 on an accepted non-zero reservation.
  - −1 on an accepted wb to a busy register.
  - Both in the same cycle: unchanged.
  - Never wraps; the maximum value is NUM_REGS−1.
- No other state and no FSM beyond the scoreboard.

Decomposition:
- Shared package jo_regfile_pkg:
  - CODE_W, DATA_W, ZERO_CODE
  - typedefs reg_code_t and reg_data_t
- One sub-module reg_scoreboard containing:
  - busy vector
  - RSV_ready logic
  - PENDING_cnt
  - WB_err
- The top level contains the data array, bypass muxes and WB_ack.

Test Plan:
- Reset, then RD_A_code=5 → RD_A_data=0, RD_A_busy=0, PENDING_cnt=0.
- Reserve 0x05, then wb code 0x05 with data 0xDEADBEEF:
  - Between the two: RD_A_busy=1 and RSV_ready for 0x05 is 0.
  - In the wb cycle: RD_A_data=0xDEADBEEF and RD_A_busy=0 via bypass.
  - Next cycle: WB_ack=1 and PENDING_cnt returns 1→0.
- wb code 0x00 with data 0x12345678 → RD_A_code=0 reads 0, WB_ack=0, WB_err=0.
- wb code 0x10 (unreserved) → WB_err=1 the next cycle and stays set; ERR_clr → 0.
- Reserve 0x07; next cycle wb 0x07 (data 0xA5) together with RSV_valid 0x07 → RSV_ready=1, reg=0xA5, busy stays 1, PENDING_cnt stays 1.
- Reserve 0x03, then assert RST_N=0 in the same cycle as wb 0x03 → after reset reg[3]=0, busy=0, WB_ack=0, PENDING_cnt=0.
